trena_digital_uc: RTL and testbench

Control unit that sequences the digital tape-measure datapath. On a start request it runs the following sequence:
- clears the datapath and triggers one HC-SR04 measurement;
- supervises the measurement with a retrying timeout;
- latches the proximity-detect flag;
- streams the 8-character frame "ccc,ddd#" through the 7O1 serial transmitter, one character per handshake.

An optional continuous mode repeats the cycle after a programmable idle interval.

---
 rtl/trena_digital_uc.sv | 172 +++++++++++++++++
 tb/tb_trena_digital_uc.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/trena_digital_uc.sv
`default_nettype none
// ============================================================================
//  Module      : trena_digital_uc
//  Description : Control unit of the digital tape measure. Clears the
//                datapath, triggers an HC-SR04 measurement with a retrying
//                timeout, latches the detect flag and streams the 8-character
//                frame through the serial transmitter, with an optional
//                continuous mode that repeats after an idle interval.
//  Revision    : 1.0 - initial release
// ============================================================================
module trena_digital_uc #(
   parameter int TIMEOUT_CICLOS   = 50000000,
   parameter int MAX_TENTATIVAS   = 3,
   parameter int NUM_CHARS        = 8,
   parameter int INTERVALO_CICLOS = 25000000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mensurar,
   input  logic       continuo,
   input  logic       medida_pronto,
   input  logic       envio_pronto,
   output logic       zera,
   output logic       medir,
   output logic       timeout,
   output logic       registra,
   output logic       transmitir,
   output logic       pronto,
   output logic       erro,
   output logic [3:0] db_estado
);

   // Counter widths: ceil(log2) of the terminal quantity, never below 1 bit.
   localparam int c_TO_W   = (TIMEOUT_CICLOS   > 1) ? $clog2(TIMEOUT_CICLOS)   : 1;
   localparam int c_TENT_W = (MAX_TENTATIVAS   > 1) ? $clog2(MAX_TENTATIVAS)   : 1;
   localparam int c_CH_W   = (NUM_CHARS        > 1) ? $clog2(NUM_CHARS)        : 1;
   localparam int c_INT_W  = (INTERVALO_CICLOS > 1) ? $clog2(INTERVALO_CICLOS) : 1;

   localparam logic [c_TO_W-1:0]  c_TO_FIM  = c_TO_W'(TIMEOUT_CICLOS - 1);
   localparam logic [c_CH_W-1:0]  c_CH_FIM  = c_CH_W'(NUM_CHARS - 1);
   localparam logic [c_INT_W-1:0] c_INT_FIM = c_INT_W'(INTERVALO_CICLOS - 1);

   typedef enum logic [3:0] {
      S_INICIAL       = 4'b0000,
      S_PREPARACAO    = 4'b0001,
      S_MEDIR         = 4'b0010,
      S_ESPERA_MEDIDA = 4'b0011,
      S_REGISTRA      = 4'b0100,
      S_TRANSMITE     = 4'b0101,
      S_ESPERA_ENVIO  = 4'b0110,
      S_FINAL         = 4'b0111,
      S_INTERVALO     = 4'b1000,
      S_ESTOURO       = 4'b1110,
      S_ERRO          = 4'b1111
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [c_TO_W-1:0]    r_to;
   logic [c_TENT_W-1:0]  r_tent;
   logic [c_CH_W-1:0]    r_char;
   logic [c_INT_W-1:0]   r_int;

   logic w_to_fim;
   logic w_char_fim;
   logic w_int_fim;
   logic w_tent_esgotou;

   assign w_to_fim       = (r_to == c_TO_FIM);
   assign w_char_fim     = (r_char == c_CH_FIM);
   assign w_int_fim      = (r_int == c_INT_FIM);
   // The attempt being closed in estouro is r_tent+1; retry only if it stays below the budget.
   assign w_tent_esgotou = ((int'(r_tent) + 1) >= MAX_TENTATIVAS);
   assign db_estado      = r_state;

   // State register, asynchronously forced to inicial.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_INICIAL;
      else        r_state <= w_next;
   end

   // Next-state logic and Moore output decode.
   always_comb begin
      w_next     = r_state;
      zera       = 1'b0;
      medir      = 1'b0;
      timeout    = 1'b0;
      registra   = 1'b0;
      transmitir = 1'b0;
      pronto     = 1'b0;
      erro       = 1'b0;
      case (r_state)
         S_INICIAL: begin
            if (mensurar) w_next = S_PREPARACAO;
         end
         S_PREPARACAO: begin
            zera   = 1'b1;
            w_next = S_MEDIR;
         end
         S_MEDIR: begin
            medir  = 1'b1;
            w_next = S_ESPERA_MEDIDA;
         end
         S_ESPERA_MEDIDA: begin
            // A measurement arriving on the terminal-count cycle still wins.
            if (medida_pronto) w_next = S_REGISTRA;
            else if (w_to_fim) w_next = S_ESTOURO;
         end
         S_ESTOURO: begin
            timeout = 1'b1;
            w_next  = w_tent_esgotou ? S_ERRO : S_PREPARACAO;
         end
         S_REGISTRA: begin
            registra = 1'b1;
            w_next   = S_TRANSMITE;
         end
         S_TRANSMITE: begin
            transmitir = 1'b1;
            w_next     = S_ESPERA_ENVIO;
         end
         S_ESPERA_ENVIO: begin
            if (envio_pronto) w_next = w_char_fim ? S_FINAL : S_TRANSMITE;
         end
         S_FINAL: begin
            pronto = 1'b1;
            if (continuo)      w_next = S_INTERVALO;
            else if (mensurar) w_next = S_PREPARACAO;
         end
         S_INTERVALO: begin
            if (!continuo)      w_next = S_INICIAL;
            else if (w_int_fim) w_next = S_PREPARACAO;
         end
         S_ERRO: begin
            erro = 1'b1;
            if (mensurar) w_next = S_INICIAL;
         end
         default: w_next = S_INICIAL;
      endcase
   end

   // Measurement timeout counter: cleared before each attempt, saturates at terminal count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                        r_to <= '0;
      else if (r_state == S_PREPARACAO)                  r_to <= '0;
      else if (r_state == S_ESPERA_MEDIDA && !w_to_fim)  r_to <= r_to + 1'b1;
   end

   // Attempt counter: one step per timeout, cleared on success or when leaving erro.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                        r_tent <= '0;
      else if (r_state == S_REGISTRA)                    r_tent <= '0;
      else if (r_state == S_ERRO && mensurar)            r_tent <= '0;
      else if (r_state == S_ESTOURO && r_tent != '1)     r_tent <= r_tent + 1'b1;
   end

   // Character counter: advances on each acknowledged character except the last.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                        r_char <= '0;
      else if (r_state == S_PREPARACAO)                  r_char <= '0;
      else if (r_state == S_ESPERA_ENVIO && envio_pronto && !w_char_fim)
                                                         r_char <= r_char + 1'b1;
   end

   // Idle-interval counter for continuous mode, saturating at terminal count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                                        r_int <= '0;
      else if (r_state == S_FINAL && continuo)           r_int <= '0;
      else if (r_state == S_INTERVALO && !w_int_fim)     r_int <= r_int + 1'b1;
   end

endmodule
`default_nettype wire

// File: tb/tb_trena_digital_uc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trena_digital_uc
//  Description : Self-checking bench for trena_digital_uc. Acts as sensor and
//                transmitter, predicts frame timing and pulse counts from the
//                sequencing rules with plain arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trena_digital_uc;

   localparam int T = 20;   // timeout cycles
   localparam int M = 3;    // attempt budget
   localparam int N = 8;    // characters per frame
   localparam int I = 30;   // idle interval

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       mensurar = 1'b0;
   logic       continuo = 1'b0;
   logic       medida_pronto = 1'b0;
   logic       envio_pronto = 1'b0;
   logic       zera, medir, timeout, registra, transmitir, pronto, erro;
   logic [3:0] db_estado;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always #5 clock = ~clock;

   trena_digital_uc #(
      .TIMEOUT_CICLOS   (T),
      .MAX_TENTATIVAS   (M),
      .NUM_CHARS        (N),
      .INTERVALO_CICLOS (I)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .mensurar      (mensurar),
      .continuo      (continuo),
      .medida_pronto (medida_pronto),
      .envio_pronto  (envio_pronto),
      .zera          (zera),
      .medir         (medir),
      .timeout       (timeout),
      .registra      (registra),
      .transmitir    (transmitir),
      .pronto        (pronto),
      .erro          (erro),
      .db_estado     (db_estado)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
      cyc++;
   endtask

   // Plays sensor and transmitter for one frame. f = attempts with the
   // measurement withheld, k = espera_medida cycle on which it arrives,
   // character acks arrive elo..ehi cycles after each transmitir.
   // pre = 1 when preparacao was already entered before the call.
   task automatic run_frame(input string tag, input bit start, input int pre, input int f,
                            input int k, input int elo, input int ehi, input int abort_tx);
      int t0, t_medir, t_env, t_tx, n_z, n_m, n_to, n_r, n_tx, sum_e, e, attempts, t_exp;
      bit ended;
      t0 = cyc - pre; t_medir = -1000; t_env = -1; t_tx = -1;
      n_z = 0; n_m = 0; n_to = 0; n_r = 0; n_tx = 0; sum_e = 0; ended = 0;
      if (start) mensurar = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         step();
         mensurar = 1'b0; medida_pronto = 1'b0; envio_pronto = 1'b0;
         if (zera) n_z++;
         if (medir) begin n_m++; t_medir = cyc; end
         if (timeout) begin
            n_to++;
            check({tag, " timeout-gap"}, cyc - t_medir, T + 1);
         end
         if (registra) n_r++;
         if (transmitir) begin
            n_tx++; t_tx = cyc;
            e = $urandom_range(ehi, elo);
            sum_e += 1 + e; t_env = cyc + e;
         end
         if (pronto || erro) begin ended = 1; break; end
         if (abort_tx > 0 && n_tx == abort_tx && cyc == t_tx + 1) begin
            check({tag, " abort-state"}, db_estado, 4'b0110);
            return;
         end
         if (n_m > f && cyc - t_medir == k) medida_pronto = 1'b1;
         if (cyc == t_env) envio_pronto = 1'b1;
         // Stray acks before the first character and stray start requests
         // mid-frame must both be ignored.
         if (n_tx == 0 && $urandom_range(3, 0) == 0) envio_pronto = 1'b1;
         if ($urandom_range(4, 0) == 0) mensurar = 1'b1;
      end
      check({tag, " ended-in-budget"}, ended, 1);
      attempts = (f >= M) ? M : f + 1;
      if (f >= M) t_exp = t0 + 1 + M * (T + 3);
      else        t_exp = t0 + 1 + f * (T + 3) + k + 3 + sum_e;
      check({tag, " end-cycle"},  cyc,       t_exp);
      check({tag, " pronto"},     pronto,    (f < M) ? 1 : 0);
      check({tag, " erro"},       erro,      (f >= M) ? 1 : 0);
      check({tag, " db_estado"},  db_estado, (f >= M) ? 15 : 7);
      check({tag, " zera-cnt"},   n_z,       attempts - pre);
      check({tag, " medir-cnt"},  n_m,       attempts);
      check({tag, " timeout-cnt"}, n_to,     (f >= M) ? M : f);
      check({tag, " registra-cnt"}, n_r,     (f < M) ? 1 : 0);
      check({tag, " tx-cnt"},     n_tx,      (f < M) ? N : 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int pf;
      // Reset state while reset is held.
      #2;
      check("rst-outs", {zera, medir, timeout, registra, transmitir, pronto, erro}, 0);
      check("rst-state", db_estado, 0);
      step(); step();
      reset = 1'b1;
      step();
      check("idle-state", db_estado, 0);
      check("idle-outs", {zera, medir, timeout, registra, transmitir, pronto, erro}, 0);

      // Single frame, fixed delays.
      run_frame("single", 1, 0, 0, 10, 5, 5, 0);
      // Timeout on first attempt, then success.
      run_frame("retry", 1, 0, 1, $urandom_range(T - 1, 1), 1, 6, 0);
      // Measurement on the terminal-count cycle.
      run_frame("simult", 1, 0, 0, T, 1, 3, 0);
      // Randomized frames.
      for (int r = 0; r < 6; r++)
         run_frame("rand", 1, 0, $urandom_range(2, 0), $urandom_range(T, 1), 1, 6, 0);

      // Retry exhaustion and recovery.
      run_frame("exhaust", 1, 0, M, 1, 1, 1, 0);
      mensurar = 1'b1;
      step();
      mensurar = 1'b0;
      check("erro-exit-state", db_estado, 0);
      check("erro-exit-flag", erro, 0);
      step();
      check("erro-exit-hold", db_estado, 0);
      run_frame("after-erro", 1, 0, 0, 5, 1, 4, 0);

      // Continuous mode: zera again I cycles after leaving final.
      continuo = 1'b1;
      pf = cyc;
      step();
      check("cont-interval", db_estado, 4'b1000);
      while (cyc < pf + I) step();
      check("cont-no-zera-early", zera, 0);
      step();
      check("cont-zera", zera, 1);
      continuo = 1'b0;
      run_frame("cont", 0, 1, 0, $urandom_range(T, 1), 1, 4, 0);

      // Dropping continuo during the interval returns to inicial.
      continuo = 1'b1;
      for (int i = 0; i < 10; i++) step();
      continuo = 1'b0;
      step();
      check("cont-drop-state", db_estado, 0);
      check("cont-drop-outs", {zera, medir, timeout, registra, transmitir, pronto, erro}, 0);

      // Asynchronous reset at character 4, then a clean restart.
      run_frame("abort", 1, 0, 0, 4, 1, 3, 5);
      #2;
      reset = 1'b0;
      #1;
      check("async-rst-state", db_estado, 0);
      check("async-rst-outs", {zera, medir, timeout, registra, transmitir, pronto, erro}, 0);
      step();
      reset = 1'b1;
      step();
      check("post-rst-idle", db_estado, 0);
      run_frame("post-rst", 1, 0, 0, 7, 1, 5, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
